// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - condition codes, NZVC flag struct and the B.cond evaluator
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_HS = 4'd2,
    COND_LO = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  // NV is treated as always-true, like AL, so decode never has to special-case it.
  function automatic logic cond_eval(input cond_e cond, input flags_t f);
    logic r;
    r = 1'b1;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = !f.z;
      COND_HS: r = f.c;
      COND_LO: r = !f.c;
      COND_MI: r = f.n;
      COND_PL: r = !f.n;
      COND_VS: r = f.v;
      COND_VC: r = !f.v;
      COND_HI: r = f.c && !f.z;
      COND_LS: r = !(f.c && !f.z);
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = !f.z && (f.n == f.v);
      COND_LE: r = !(!f.z && (f.n == f.v));
      COND_AL: r = 1'b1;
      COND_NV: r = 1'b1;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_reg.sv
// rtl/flag_reg.sv - architectural NZVC register: 2:1 hold/load mux feeding a D flop bank
import cpu_pkg::*;

module flag_reg (
  input  logic   clk,
  input  logic   reset,
  input  logic   we_i,
  input  flags_t d_i,
  output flags_t q_o
);

  flags_t flags_d;
  flags_t flags_q;

  always_comb begin
    flags_d = flags_q;
    if (we_i) begin
      flags_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign q_o = flags_q;

endmodule

// File: rtl/flag_hazard_ctrl.sv
// rtl/flag_hazard_ctrl.sv - tracks flag-setters from ID to EX, owns NZVC and resolves B.cond in ID
import cpu_pkg::*;

module flag_hazard_ctrl #(
  parameter int FWD_EX = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_sets_flags,
  input  logic             id_is_bcond,
  input  logic [3:0]       id_cond,
  input  logic             ext_stall,
  input  logic             flush,
  input  logic             alu_neg,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic             flag_en,
  output logic [3:0]       nzvc,
  output logic             br_taken,
  output logic             stall_out,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit USE_FWD = (FWD_EX != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             ex_sets_flags_q;
  logic             ex_sets_flags_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  flags_t           alu_flags;
  flags_t           nzvc_q;
  flags_t           eval_flags;
  logic             cond_true;
  logic             stall_w;
  logic             br_w;

  assign alu_flags = {alu_neg, alu_zero, alu_overflow, alu_carry_out};

  flag_reg u_flag_reg (
    .clk   (clk),
    .reset (reset),
    .we_i  (ex_sets_flags_q),
    .d_i   (alu_flags),
    .q_o   (nzvc_q)
  );

  // A flag-setter in EX makes nzvc stale for ID: either bypass the live ALU
  // flags, or hold ID for the one cycle it takes them to land in nzvc.
  always_comb begin
    eval_flags = nzvc_q;
    if (USE_FWD && ex_sets_flags_q) begin
      eval_flags = alu_flags;
    end
  end

  assign cond_true = cond_eval(cond_e'(id_cond), eval_flags);

  always_comb begin
    stall_w = 1'b0;
    br_w    = 1'b0;
    if (!reset && !flush && id_valid && id_is_bcond) begin
      stall_w = !USE_FWD && ex_sets_flags_q;
      br_w    = !stall_w && !ext_stall && cond_true;
    end
  end

  // Any stall or flush turns the EX slot into a bubble; the tracker never holds.
  assign ex_sets_flags_d = id_valid && id_sets_flags && !flush && !stall_w && !ext_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_sets_flags_q <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      ex_sets_flags_q <= ex_sets_flags_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign flag_en   = ex_sets_flags_q;
  assign nzvc      = nzvc_q;
  assign br_taken  = br_w;
  assign stall_out = stall_w;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/flag_hazard_ctrl.md
Name: flag_hazard_ctrl

Overview:
Controller for the pipelined CPU's NZVC condition-flag register. It tracks flag-setting instructions from ID into EX and generates the flag write enable. It owns the architectural NZVC state and resolves B.cond in ID, either by forwarding live ALU flags or by stalling ID one cycle. It sits between the decode unit, the EX-stage ALU and the fetch/PC-select logic.

Parameters:
FWD_EX, 1, 1 = forward EX ALU flags to ID branch evaluation; 0 = stall ID one cycle instead.
CNT_W, 16, width of the saturating flag-stall performance counter.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_sets_flags  input  1  ID instruction writes flags (ADDS/SUBS/ANDS...)
id_is_bcond  input  1  ID instruction is B.cond
id_cond  input  4  ARM condition code of B.cond (0=EQ ... 14=AL, 15=NV)
ext_stall  input  1  stall ID from other hazard logic (e.g. load-use)
flush  input  1  kill ID instruction (taken branch/redirect)
alu_neg, alu_zero, alu_overflow, alu_carry_out  input  1 each  EX-stage ALU flag outputs
flag_en  output  1  EX instruction commits flags this cycle
nzvc  output  4  architectural flags {N,Z,V,C}, registered
br_taken  output  1  ID B.cond resolved taken this cycle
stall_out  output  1  this block requests ID/IF stall
stall_cnt  output  CNT_W  number of cycles stall_out was high

Behaviour:
- Reset (sync, high): nzvc=4'b0000; ex_sets_flags=0; flag_en=0; stall_cnt=0. br_taken and stall_out are 0 while reset is high.
- ID->EX tracking register ex_sets_flags. On each edge it takes id_valid & id_sets_flags & ~flush & ~stall_out & ~ext_stall. Any stall or flush inserts a bubble; it never holds.
- flag_en = ex_sets_flags (combinational). On the edge with flag_en=1, nzvc <= {alu_neg, alu_zero, alu_overflow, alu_carry_out}. Otherwise nzvc holds.
- Eval flags F:
  - FWD_EX=1 and ex_sets_flags: F = live ALU flags.
  - Otherwise: F = nzvc.
- Condition decode on F:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V.
  - GT !Z&(N==V); LE !(!Z&(N==V)); AL 1; NV 1.
- stall_out = (FWD_EX==0) & id_valid & id_is_bcond & ex_sets_flags & ~flush.
  - This lasts exactly one cycle: the next EX is a bubble and nzvc is then updated.
- br_taken = id_valid & id_is_bcond & ~stall_out & ~ext_stall & ~flush & cond(F).
- Simultaneous events:
  - flush overrides all: no stall_out, no br_taken, a bubble enters EX.
  - ext_stall with a pending flag stall: stall_out may also assert; EX gets a bubble either way.
  - A flag write in EX coincident with a B.cond in ID: forward (FWD_EX=1) or stall (FWD_EX=0). The branch must never see stale flags.
- Back-to-back flag-setters: each commits in order, one per cycle.
- stall_cnt increments on every cycle stall_out=1 and saturates at all-ones.
- Reset mid-stall: stall_out drops the same cycle; the tracking register and nzvc clear on that edge.

Decomposition:
- Shared package (cpu_pkg):
  - cond_e enum for the 16 condition codes.
  - flags_t packed struct {n,z,v,c}.
  - cond_eval function (cond_e, flags_t) -> logic, reused by any later branch unit.
- Sub-module flag_reg: the 4-bit NZVC register with write enable and synchronous reset. Built from the codebase's D_FF and 2:1 mux cells.
- Tracking register, forward mux, stall logic and counter live in the top.

Test Plan:
- FWD_EX=1: SUBS in EX with ALU Z=1, B.EQ in ID same cycle -> br_taken=1, stall_out=0. nzvc=4'b0100 after the edge.
- FWD_EX=0, same stimulus -> stall_out=1 for exactly one cycle, br_taken=0 that cycle. Next cycle nzvc=4'b0100, br_taken=1, stall_cnt=1.
- ADDS sets nzvc=4'b1010, then non-flag ADD with ALU flags 0000, then B.GE -> flag_en=0 for the ADD, nzvc stays 1010, br_taken=1 (N==V).
- Flag-setter in ID with flush=1 -> next cycle flag_en=0, nzvc unchanged. B.cond in ID with flush -> br_taken=0.
- Reset asserted during a FWD_EX=0 stall -> stall_out=0 the same cycle. After the edge: nzvc=0000, stall_cnt=0, flag_en=0.
- Sweep all 16 id_cond values against all 16 nzvc values -> br_taken matches the condition table (AL/NV always 1).
